// File: rtl/reg_mon_pkg.sv
// reg_mon_pkg: shared helpers for reg_change_monitor.
// Contents:
//   MAX_CH     - largest supported channel count. Helpers operate on vectors
//                zero-extended to this width.
//   MAX_IDX_W  - index width for MAX_CH channels.
//   CNT_OUT_W  - width of a popcount result over MAX_CH bits.
//   lowest_set - index of the lowest set bit. Returns 0 for an all-zero vector.
//   popcount   - number of set bits.
// Because a package cannot see a module parameter, IDX_W = $clog2(N_CH) is
// declared in the top module.
package reg_mon_pkg;

  localparam int unsigned MAX_CH    = 64;
  localparam int unsigned MAX_IDX_W = 6;
  localparam int unsigned CNT_OUT_W = 7;

  function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [MAX_CH-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    // Scan from the top down so that the lowest set bit is written last.
    for (int unsigned i = MAX_CH; i > 0; i--) begin
      if (v[i-1]) idx = MAX_IDX_W'(i - 1);
    end
    return idx;
  endfunction

  function automatic logic [CNT_OUT_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [CNT_OUT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      n = n + CNT_OUT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_mon_channel.sv
// reg_mon_channel: per-channel state for the change monitor.
// Each instance holds the previous word, a hold counter and a sticky bit.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   data_in      - current word for this channel
//   sample_en    - compare this word and update prev in this cycle
//   sticky       - a change sets the sticky bit
//   clear        - synchronous clear; also reloads prev
//   primed       - global primed flag (registered in the top module)
//   chg          - change detected this cycle (combinational, registered by the top)
//   flag         - highlight: hold counter nonzero or sticky bit set
module reg_mon_channel #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HOLD_W      = 16,
  parameter int unsigned HOLD_CYCLES = 16'hFFFF,
  parameter bit          IGNORE      = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sample_en,
  input  logic              sticky,
  input  logic              clear,
  input  logic              primed,
  output logic              chg,
  output logic              flag
);

  logic [DATA_W-1:0] prev_q,   prev_d;
  logic [HOLD_W-1:0] cnt_q,    cnt_d;
  logic              sticky_q, sticky_d;

  always_comb begin
    chg      = 1'b0;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;

    if (clear) begin
      prev_d   = data_in;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else begin
      chg = primed && sample_en && !IGNORE && (data_in != prev_q);
      if (sample_en) prev_d = data_in;
      if (chg) begin
        cnt_d = HOLD_W'(HOLD_CYCLES);
        if (sticky) sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign flag = (cnt_q != '0) | sticky_q;

endmodule

// File: rtl/reg_change_monitor.sv
// reg_change_monitor: watches N_CH data words and flags each word that changes.
// A flag is held for HOLD_CYCLES cycles, or latched until clear when sticky is set.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   data_in       - channel i is at bits [i*DATA_W +: DATA_W]
//   sample_en     - 1 = compare and update in this cycle
//   sticky        - 1 = latch flags until clear
//   clear         - synchronous clear of flags, counters and statistics
//   changed_mask  - highlight flag per channel
//   change_pulse  - one-cycle strobe per detected change
//   last_ch       - lowest index among the most recent set of changes
//   last_valid    - last_ch holds a valid index
//   change_count  - saturating count of channel-change events
module reg_change_monitor
  import reg_mon_pkg::*;
#(
  parameter int unsigned        N_CH        = 32,
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        HOLD_W      = 16,
  parameter int unsigned        HOLD_CYCLES = 16'hFFFF,
  parameter int unsigned        CNT_W       = 16,
  parameter logic [N_CH-1:0]    IGNORE_MASK = N_CH'(1),
  localparam int unsigned       IDX_W       = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic                   sample_en,
  input  logic                   sticky,
  input  logic                   clear,
  output logic [N_CH-1:0]        changed_mask,
  output logic [N_CH-1:0]        change_pulse,
  output logic [IDX_W-1:0]       last_ch,
  output logic                   last_valid,
  output logic [CNT_W-1:0]       change_count
);

  // The accumulator is wide enough that count plus a full-width popcount never wraps.
  localparam int unsigned SUM_W = ((CNT_W > CNT_OUT_W) ? CNT_W : CNT_OUT_W) + 1;

  logic [N_CH-1:0]  chg_vec;
  logic [N_CH-1:0]  flag_vec;

  logic             primed_q,     primed_d;
  logic [N_CH-1:0]  pulse_q,      pulse_d;
  logic [IDX_W-1:0] last_ch_q,    last_ch_d;
  logic             last_valid_q, last_valid_d;
  logic [CNT_W-1:0] count_q,      count_d;
  logic [SUM_W-1:0] sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    reg_mon_channel #(
      .DATA_W      (DATA_W),
      .HOLD_W      (HOLD_W),
      .HOLD_CYCLES (HOLD_CYCLES),
      .IGNORE      (IGNORE_MASK[i])
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .data_in   (data_in[i*DATA_W +: DATA_W]),
      .sample_en (sample_en),
      .sticky    (sticky),
      .clear     (clear),
      .primed    (primed_q),
      .chg       (chg_vec[i]),
      .flag      (flag_vec[i])
    );
  end

  always_comb begin
    primed_d     = primed_q | sample_en | clear;
    pulse_d      = chg_vec;
    last_ch_d    = last_ch_q;
    last_valid_d = last_valid_q;
    sum          = SUM_W'(count_q) + SUM_W'(popcount(MAX_CH'(chg_vec)));
    count_d      = (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];

    if (|chg_vec) begin
      last_ch_d    = IDX_W'(lowest_set(MAX_CH'(chg_vec)));
      last_valid_d = 1'b1;
    end

    // The channels already suppress chg during clear. Zero everything explicitly anyway.
    if (clear) begin
      pulse_d      = '0;
      last_ch_d    = '0;
      last_valid_d = 1'b0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed_q     <= 1'b0;
      pulse_q      <= '0;
      last_ch_q    <= '0;
      last_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      primed_q     <= primed_d;
      pulse_q      <= pulse_d;
      last_ch_q    <= last_ch_d;
      last_valid_q <= last_valid_d;
      count_q      <= count_d;
    end
  end

  assign changed_mask = flag_vec;
  assign change_pulse = pulse_q;
  assign last_ch      = last_ch_q;
  assign last_valid   = last_valid_q;
  assign change_count = count_q;

endmodule

// File: tb/tb_reg_change_monitor.sv
module tb_reg_change_monitor;

  localparam int N_CH   = 32;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [N_CH*DATA_W-1:0] data_in;
  logic                   sample_en;
  logic                   sticky;
  logic                   clear;
  logic [N_CH-1:0]        changed_mask;
  logic [N_CH-1:0]        change_pulse;
  logic [4:0]             last_ch;
  logic                   last_valid;
  logic [3:0]             change_count;

  int checks = 0;
  int errors = 0;

  reg_change_monitor #(
    .N_CH        (N_CH),
    .DATA_W      (DATA_W),
    .HOLD_W      (16),
    .HOLD_CYCLES (4),
    .CNT_W       (4),
    .IGNORE_MASK (32'h1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .sample_en    (sample_en),
    .sticky       (sticky),
    .clear        (clear),
    .changed_mask (changed_mask),
    .change_pulse (change_pulse),
    .last_ch      (last_ch),
    .last_valid   (last_valid),
    .change_count (change_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] v);
    data_in[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; data_in = '0; sample_en = 1'b0; sticky = 1'b0; clear = 1'b0;
    tick(); tick();
    checks++;
    if ({changed_mask, change_pulse, last_ch, last_valid, change_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: mask=%h pulse=%h last=%0d valid=%b cnt=%0d required all 0",
               changed_mask, change_pulse, last_ch, last_valid, change_count);
    end
    reset_n = 1'b1;
    tick();
    // Priming cycle: data differs from the reset value of prev but must not pulse.
    set_ch(5, 32'h0); set_ch(4, 32'h77);
    sample_en = 1'b1;
    tick();
    checks++;
    if (change_pulse !== '0 || change_count !== 4'd0) begin
      errors++;
      $display("FAIL prime_no_pulse: pulse=%h cnt=%0d required 0/0", change_pulse, change_count);
    end
  endtask

  task automatic test_single();
    int hi;
    set_ch(5, 32'h1234);
    tick();
    checks++;
    if (change_pulse !== 32'h20 || last_ch !== 5'd5 || last_valid !== 1'b1 || change_count !== 4'd1) begin
      errors++;
      $display("FAIL single_change: pulse=%h last=%0d valid=%b cnt=%0d required 00000020/5/1/1",
               change_pulse, last_ch, last_valid, change_count);
    end
    hi = changed_mask[5] ? 1 : 0;
    tick();
    checks++;
    if (change_pulse !== '0) begin
      errors++;
      $display("FAIL pulse_one_cycle: pulse=%h required 0", change_pulse);
    end
    for (int i = 0; i < 10; i++) begin
      if (changed_mask[5]) hi++;
      tick();
    end
    checks++;
    if (hi !== 4) begin
      errors++;
      $display("FAIL hold_duration: mask high %0d cycles required 4", hi);
    end
  endtask

  task automatic test_simultaneous();
    set_ch(0, 32'hAAAA); set_ch(31, 32'hBBBB);
    tick();
    checks++;
    if (change_pulse !== 32'h8000_0000 || changed_mask !== 32'h8000_0000 ||
        last_ch !== 5'd31 || change_count !== 4'd2) begin
      errors++;
      $display("FAIL ignore_ch0: pulse=%h mask=%h last=%0d cnt=%0d required 80000000/80000000/31/2",
               change_pulse, changed_mask, last_ch, change_count);
    end
    set_ch(3, 32'h3); set_ch(9, 32'h9);
    tick();
    checks++;
    if (change_pulse !== 32'h0000_0208 || last_ch !== 5'd3 || change_count !== 4'd4) begin
      errors++;
      $display("FAIL two_at_once: pulse=%h last=%0d cnt=%0d required 00000208/3/4",
               change_pulse, last_ch, change_count);
    end
  endtask

  task automatic test_sticky();
    sticky = 1'b1;
    set_ch(7, 32'h7);
    tick();
    sticky = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (changed_mask[7] !== 1'b1 || changed_mask !== 32'h80 || change_count !== 4'd5) begin
      errors++;
      $display("FAIL sticky_hold: mask=%h cnt=%0d required 00000080/5", changed_mask, change_count);
    end
    // A clear in the same cycle as a data change suppresses the pulse.
    clear = 1'b1;
    set_ch(7, 32'h8);
    tick();
    clear = 1'b0;
    checks++;
    if (changed_mask !== '0 || change_pulse !== '0 || change_count !== 4'd0 ||
        last_valid !== 1'b0 || last_ch !== 5'd0) begin
      errors++;
      $display("FAIL clear_all: mask=%h pulse=%h cnt=%0d valid=%b last=%0d required all 0",
               changed_mask, change_pulse, change_count, last_valid, last_ch);
    end
    tick();
    checks++;
    if (change_pulse !== '0) begin
      errors++;
      $display("FAIL clear_loads_prev: pulse=%h required 0", change_pulse);
    end
  endtask

  task automatic test_retrigger();
    int hi;
    set_ch(2, 32'h22);
    tick();
    tick(); tick();
    set_ch(2, 32'h23);
    tick();
    checks++;
    if (change_pulse !== 32'h4 || change_count !== 4'd2) begin
      errors++;
      $display("FAIL retrigger_pulse: pulse=%h cnt=%0d required 00000004/2", change_pulse, change_count);
    end
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (changed_mask[2]) hi++;
      tick();
    end
    checks++;
    if (hi !== 4) begin
      errors++;
      $display("FAIL retrigger_hold: mask high %0d cycles required 4", hi);
    end
  endtask

  task automatic test_sample_en();
    set_ch(4, 32'h1);
    tick();
    sample_en = 1'b0;
    set_ch(4, 32'h2); tick();
    set_ch(4, 32'h1); tick();
    checks++;
    if (change_pulse !== '0) begin
      errors++;
      $display("FAIL frozen_no_pulse: pulse=%h required 0", change_pulse);
    end
    sample_en = 1'b1;
    tick();
    checks++;
    if (change_pulse !== '0 || change_count !== 4'd3) begin
      errors++;
      $display("FAIL net_zero: pulse=%h cnt=%0d required 0/3", change_pulse, change_count);
    end
    sample_en = 1'b0;
    set_ch(4, 32'h2); tick(); tick();
    sample_en = 1'b1;
    tick();
    checks++;
    if (change_pulse !== 32'h10 || change_count !== 4'd4 || last_ch !== 5'd4) begin
      errors++;
      $display("FAIL net_change: pulse=%h cnt=%0d last=%0d required 00000010/4/4",
               change_pulse, change_count, last_ch);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int j = 0; j < 20; j++) begin
      set_ch((j % 30) + 1, 32'(j + 1000));
      tick();
      exp = (j + 1 > 15) ? 4'd15 : 4'(j + 1);
      checks++;
      if (change_count !== exp) begin
        errors++;
        $display("FAIL saturate_step%0d: cnt=%0d required %0d", j, change_count, exp);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    set_ch(6, 32'h6666);
    tick();
    checks++;
    if (changed_mask[6] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hold: mask6=%b required 1", changed_mask[6]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({changed_mask, change_pulse, last_ch, last_valid, change_count} !== '0) begin
      errors++;
      $display("FAIL async_reset: mask=%h pulse=%h last=%0d valid=%b cnt=%0d required all 0",
               changed_mask, change_pulse, last_ch, last_valid, change_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_sticky();
    test_retrigger();
    test_sample_en();
    test_saturation();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
